// File: rtl/sdhci_cmd_pkg.sv
// Types and constants shared by the SD command arbiter and its watchdog.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sdhci_cmd_pkg;

  // Response format expected after a command has been shifted out
  typedef enum logic [1:0] {
    RSP_NONE    = 2'd0,
    RSP_136     = 2'd1,
    RSP_48      = 2'd2,
    RSP_48_BUSY = 2'd3
  } rsp_type_e;

  // Command request as presented by a requester and forwarded to the engine
  typedef struct packed {
    logic [5:0]  index;
    logic [31:0] arg;
    rsp_type_e   rsp_type;
    logic        data_present;
    logic        is_abort;
  } cmd_req_t;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_SENT = 2'd2,
    ST_WAIT_RSP  = 2'd3
  } arb_state_e;

  localparam logic [5:0] CMD12_INDEX = 6'd12;

  // Fixed auto-CMD12 request: STOP_TRANSMISSION, R1b, abort class
  function automatic cmd_req_t make_cmd12(input logic [31:0] arg);
    cmd_req_t c;
    c.index        = CMD12_INDEX;
    c.arg          = arg;
    c.rsp_type     = RSP_48_BUSY;
    c.data_present = 1'b0;
    c.is_abort     = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/sdhci_cmd_watchdog.sv
// Stall counter for an outstanding command: cleared by load, counts while enabled.
// Latency: expired is combinational from the count register; asserts once count reaches Limit-1.
// Backpressure: none; the count saturates once expired so the flag stays up until reload.
module sdhci_cmd_watchdog #(
  parameter logic [31:0] Limit = 32'd1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [31:0] cnt;

  assign expired = en && (cnt >= (Limit - 32'd1));

  // Count register: clear on load, otherwise advance while enabled and not yet expired
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 32'd0;
    end else if (load) begin
      cnt <= 32'd0;
    end else if (en && !expired) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/sdhci_cmd_arbiter.sv
// Shares the SD command engine between software commands and auto-CMD12; optional watchdog via SDHCI_CMD_WATCHDOG_EN.
// Latency: grant one cycle after request seen in IDLE, cmd_valid_o the cycle after grant; all outputs registered.
// Backpressure: cmd_valid_o/cmd_o held until cmd_ready_i; requests stay pending while a command is in flight.
module sdhci_cmd_arbiter
  import sdhci_cmd_pkg::*;
#(
  parameter logic [31:0] Cmd12Arg       = 32'h0000_0000,
  parameter logic [31:0] WatchdogCycles = 32'd1_000_000
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     sw_req_i,
  input  cmd_req_t sw_cmd_i,
  output logic     sw_gnt_o,
  input  logic     acmd12_req_i,
  output logic     acmd12_gnt_o,
  input  logic     dat_busy_i,
  output logic     cmd_valid_o,
  input  logic     cmd_ready_i,
  output cmd_req_t cmd_o,
  output logic     cmd_is_auto_o,
  input  logic     cmd_done_i,
  input  logic     rsp_done_i,
  input  logic     rsp_error_i,
  output logic     inhibit_cmd_o,
  output logic     cmd_complete_o,
  output logic     acmd12_complete_o,
  output logic     acmd12_error_o,
  output logic     timeout_o
);

  arb_state_e state, state_nxt;

  logic     sw_gnt_nxt, acmd12_gnt_nxt, cmd_valid_nxt, cmd_is_auto_nxt;
  logic     inhibit_nxt, cmd_complete_nxt, acmd12_complete_nxt, acmd12_error_nxt;
  logic     timeout_nxt;
  cmd_req_t cmd_nxt;

  logic     sw_ok, issue_hs, sent_evt, rsp_evt, wd_expire, wd_fire, finish;
  cmd_req_t cmd12;

  assign cmd12 = make_cmd12(Cmd12Arg);

  // A data command must not start while DAT is busy unless it is an abort
  assign sw_ok    = sw_req_i && !(sw_cmd_i.data_present && dat_busy_i && !sw_cmd_i.is_abort);
  assign issue_hs = (state == ST_ISSUE) && cmd_valid_o && cmd_ready_i;
  assign sent_evt = (state == ST_WAIT_SENT) && cmd_done_i;
  assign rsp_evt  = (state == ST_WAIT_RSP) && rsp_done_i;
  // A done pulse landing in the expiry cycle wins over the timeout
  assign wd_fire  = wd_expire && (((state == ST_WAIT_SENT) && !cmd_done_i) ||
                                  ((state == ST_WAIT_RSP) && !rsp_done_i));
  assign finish   = (sent_evt && (cmd_o.rsp_type == RSP_NONE)) || rsp_evt || wd_fire;

`ifdef SDHCI_CMD_WATCHDOG_EN
  logic wd_en;
  assign wd_en = (state == ST_WAIT_SENT) || (state == ST_WAIT_RSP);

  sdhci_cmd_watchdog #(
    .Limit(WatchdogCycles)
  ) u_watchdog (
    .clk    (clk_i),
    .rst    (rst_i),
    .load   (issue_hs),
    .en     (wd_en),
    .expired(wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  // State and registered outputs; reset abandons any command in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= ST_IDLE;
      sw_gnt_o          <= 1'b0;
      acmd12_gnt_o      <= 1'b0;
      cmd_valid_o       <= 1'b0;
      cmd_o             <= '0;
      cmd_is_auto_o     <= 1'b0;
      inhibit_cmd_o     <= 1'b0;
      cmd_complete_o    <= 1'b0;
      acmd12_complete_o <= 1'b0;
      acmd12_error_o    <= 1'b0;
      timeout_o         <= 1'b0;
    end else begin
      state             <= state_nxt;
      sw_gnt_o          <= sw_gnt_nxt;
      acmd12_gnt_o      <= acmd12_gnt_nxt;
      cmd_valid_o       <= cmd_valid_nxt;
      cmd_o             <= cmd_nxt;
      cmd_is_auto_o     <= cmd_is_auto_nxt;
      inhibit_cmd_o     <= inhibit_nxt;
      cmd_complete_o    <= cmd_complete_nxt;
      acmd12_complete_o <= acmd12_complete_nxt;
      acmd12_error_o    <= acmd12_error_nxt;
      timeout_o         <= timeout_nxt;
    end
  end

  // Next-state: grant from IDLE, handshake, then wait for send and optional response
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (acmd12_req_i || sw_ok) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (issue_hs) state_nxt = ST_WAIT_SENT;
      end
      ST_WAIT_SENT: begin
        if (cmd_done_i) begin
          state_nxt = (cmd_o.rsp_type == RSP_NONE) ? ST_IDLE : ST_WAIT_RSP;
        end else if (wd_fire) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_done_i || wd_fire) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    sw_gnt_nxt          = 1'b0;
    acmd12_gnt_nxt      = 1'b0;
    cmd_nxt             = cmd_o;
    cmd_is_auto_nxt     = cmd_is_auto_o;
    cmd_valid_nxt       = 1'b0;
    inhibit_nxt         = (state != ST_IDLE);
    cmd_complete_nxt    = 1'b0;
    acmd12_complete_nxt = 1'b0;
    acmd12_error_nxt    = 1'b0;
    timeout_nxt         = wd_fire;

    // Auto-CMD12 has priority; the grant pulse is issued as ISSUE is entered
    if (state == ST_IDLE) begin
      acmd12_gnt_nxt = acmd12_req_i;
      sw_gnt_nxt     = !acmd12_req_i && sw_ok;
    end

    // The command is captured during the grant pulse and valid rises right after it
    if (state == ST_ISSUE) begin
      cmd_valid_nxt = !(cmd_valid_o && cmd_ready_i);
      if (acmd12_gnt_o) begin
        cmd_nxt         = cmd12;
        cmd_is_auto_nxt = 1'b1;
      end else if (sw_gnt_o) begin
        cmd_nxt         = sw_cmd_i;
        cmd_is_auto_nxt = 1'b0;
      end
    end

    if (finish) begin
      cmd_complete_nxt    = !cmd_is_auto_o;
      acmd12_complete_nxt = cmd_is_auto_o;
      acmd12_error_nxt    = cmd_is_auto_o && (wd_fire || (rsp_evt && rsp_error_i));
    end
  end

endmodule
